// File: rtl/codec_ctrl_target.sv
// -----------------------------------------------------------------------------
// codec_ctrl_target
//
// Serial control-port responder for the codec control interface. Receives
// 16-bit write frames (7-bit address, 9-bit data, MSB first) on the same
// spi_sck/spi_mosi/cs wires driven by the codec configurator, and applies
// them to a shadow register bank R0..R9 with the codec's register semantics.
// Address 0x0F resets the bank to defaults; other unmapped addresses are
// flagged with addr_err and leave the bank untouched.
//
// Optional feature macro: CODEC_LRBOTH_EN
//   defined   : a write to R0/R1 (or R2/R3) with data[8]=1 updates both
//               registers of the pair.
//   undefined : only the addressed register is written; bit 8 is stored.
//
// Parameters:
//   NUM_BITS    - frame length in SCK rising edges (frame accepted only at
//                 exactly this count)
//   SYNC_STAGES - synchronizer depth for spi_sck, spi_mosi and cs (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   spi_sck    in   serial clock from initiator (async to clk)
//   spi_mosi   in   serial data, sampled on SCK rise
//   cs         in   latch strobe, rising edge commits the frame
//   rd_addr    in   [6:0] register read address
//   rd_data    out  [8:0] registered read data (unmapped reads 0)
//   wr_valid   out  one-cycle pulse per committed frame
//   wr_addr    out  [6:0] address of last committed frame
//   wr_data    out  [8:0] data of last committed frame
//   frame_err  out  one-cycle pulse: cs rise with bit count != NUM_BITS
//   addr_err   out  one-cycle pulse: committed frame to an unmapped address
//   active     out  R9[0]
//   master     out  R7[6]
//   iwl        out  [1:0] R7[3:2]
//   format     out  [1:0] R7[1:0]
//   sr         out  [3:0] R8[5:2]
//   outpd      out  R6[4]
// -----------------------------------------------------------------------------
module codec_ctrl_target #(
   parameter int NUM_BITS    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   input  logic       cs,
   input  logic [6:0] rd_addr,
   output logic [8:0] rd_data,
   output logic       wr_valid,
   output logic [6:0] wr_addr,
   output logic [8:0] wr_data,
   output logic       frame_err,
   output logic       addr_err,
   output logic       active,
   output logic       master,
   output logic [1:0] iwl,
   output logic [1:0] format,
   output logic [3:0] sr,
   output logic       outpd
);

   localparam int NUM_REGS = 10;
   localparam int CNT_W    = $clog2(NUM_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_BITS);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(NUM_BITS + 1);
   localparam logic [6:0] ADDR_RESET = 7'h0F;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   // Power-on / soft-reset contents of the register bank.
   function automatic logic [8:0] reg_default(input int idx);
      case (idx)
         0:       reg_default = 9'h097;
         1:       reg_default = 9'h097;
         2:       reg_default = 9'h079;
         3:       reg_default = 9'h079;
         4:       reg_default = 9'h00A;
         5:       reg_default = 9'h008;
         6:       reg_default = 9'h09F;
         7:       reg_default = 9'h00A;
         default: reg_default = 9'h000;
      endcase
   endfunction

   function automatic logic is_mapped(input logic [6:0] addr);
      is_mapped = (addr < 7'(NUM_REGS)) || (addr == ADDR_RESET);
   endfunction

   logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
   logic                   sck_dly, cs_dly;
   logic                   sck_s, mosi_s, cs_s;
   logic                   sck_rise, cs_rise;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_upd;
   logic [15:0]      shift_reg;
   logic [15:0]      shift_nxt;

   logic [8:0] bank     [NUM_REGS];
   logic [8:0] bank_nxt [NUM_REGS];

   // ---- Pin synchronizers and edge detection ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sck_sync  <= '0;
         mosi_sync <= '0;
         cs_sync   <= '0;
         sck_dly   <= 1'b0;
         cs_dly    <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
         sck_dly   <= sck_s;
         cs_dly    <= cs_s;
      end
   end

   assign sck_s    = sck_sync[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync[SYNC_STAGES-1];
   assign cs_s     = cs_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_dly;
   assign cs_rise  = cs_s & ~cs_dly;

   // A same-cycle SCK rise is folded in before CS is evaluated, so the
   // commit decision and the captured frame both see the latest bit.
   always_comb begin
      shift_nxt = shift_reg;
      cnt_upd   = cnt;
      if (sck_rise) begin
         shift_nxt = {shift_reg[14:0], mosi_s};
         cnt_upd   = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
      end
   end

   // ---- Frame FSM: shift, count, commit ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         shift_reg <= '0;
         wr_valid  <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         wr_valid  <= 1'b0;
         frame_err <= 1'b0;
         addr_err  <= 1'b0;
         shift_reg <= shift_nxt;

         case (state)
            S_IDLE, S_SHIFT: begin
               if (cs_rise) begin
                  cnt <= '0;
                  if (cnt_upd == CNT_FULL) begin
                     state    <= S_COMMIT;
                     wr_valid <= 1'b1;
                     wr_addr  <= shift_nxt[15:9];
                     wr_data  <= shift_nxt[8:0];
                     addr_err <= ~is_mapped(shift_nxt[15:9]);
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_IDLE;
                  end
               end else if (sck_rise) begin
                  cnt   <= cnt_upd;
                  state <= S_SHIFT;
               end
            end
            S_COMMIT: begin
               // An SCK rise here is the first bit of the next frame.
               if (cs_rise) begin
                  cnt       <= '0;
                  frame_err <= 1'b1;
                  state     <= S_IDLE;
               end else if (sck_rise) begin
                  cnt   <= CNT_W'(1);
                  state <= S_SHIFT;
               end else begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   // ---- Register bank update (applied during COMMIT from the latched frame) ----
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         bank_nxt[i] = bank[i];
      end
      if (state == S_COMMIT) begin
         if (wr_addr == ADDR_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               bank_nxt[i] = reg_default(i);
            end
         end else if (wr_addr < 7'(NUM_REGS)) begin
            bank_nxt[wr_addr[3:0]] = wr_data;
`ifdef CODEC_LRBOTH_EN
            if (wr_data[8]) begin
               if (wr_addr == 7'd0 || wr_addr == 7'd1) begin
                  bank_nxt[0] = wr_data;
                  bank_nxt[1] = wr_data;
               end
               if (wr_addr == 7'd2 || wr_addr == 7'd3) begin
                  bank_nxt[2] = wr_data;
                  bank_nxt[3] = wr_data;
               end
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] <= reg_default(i);
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] <= bank_nxt[i];
         end
      end
   end

   // ---- Read port: reads the next-state bank so a write is visible with
   // the same latency as the bank itself ----
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data <= '0;
      end else if (rd_addr < 7'(NUM_REGS)) begin
         rd_data <= bank_nxt[rd_addr[3:0]];
      end else begin
         rd_data <= '0;
      end
   end

   assign active = bank[9][0];
   assign master = bank[7][6];
   assign iwl    = bank[7][3:2];
   assign format = bank[7][1:0];
   assign sr     = bank[8][5:2];
   assign outpd  = bank[6][4];

endmodule

// File: tb/tb_codec_ctrl_target.sv
// -----------------------------------------------------------------------------
// tb_codec_ctrl_target
//
// Directed testbench for codec_ctrl_target: drives serial write frames on
// spi_sck/spi_mosi/cs and checks the write strobes, error pulses, register
// bank read-back and decoded format outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_codec_ctrl_target;

   localparam int HALF = 6;  // clk cycles per SCK phase / CS high phase

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       cs = 1'b0;
   logic [6:0] rd_addr = 7'd0;
   logic [8:0] rd_data;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       frame_err;
   logic       addr_err;
   logic       active;
   logic       master;
   logic [1:0] iwl;
   logic [1:0] format;
   logic [3:0] sr;
   logic       outpd;

   int checks = 0;
   int errors = 0;

   // Cycle counts of each pulse output being high.
   int wr_cnt = 0;
   int ferr_cnt = 0;
   int aerr_cnt = 0;

   codec_ctrl_target #(
      .NUM_BITS   (16),
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .spi_sck  (spi_sck),
      .spi_mosi (spi_mosi),
      .cs       (cs),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .frame_err(frame_err),
      .addr_err (addr_err),
      .active   (active),
      .master   (master),
      .iwl      (iwl),
      .format   (format),
      .sr       (sr),
      .outpd    (outpd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_valid)  wr_cnt   <= wr_cnt + 1;
      if (frame_err) ferr_cnt <= ferr_cnt + 1;
      if (addr_err)  aerr_cnt <= aerr_cnt + 1;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Shift out the n most significant bits of f, MSB first.
   task automatic send_bits(input logic [15:0] f, input int n);
      for (int i = 15; i > 15 - n; i--) begin
         spi_mosi = f[i];
         wait_clk(HALF);
         spi_sck = 1'b1;
         wait_clk(HALF);
         spi_sck = 1'b0;
      end
   endtask

   task automatic pulse_cs;
      wait_clk(HALF);
      cs = 1'b1;
      wait_clk(HALF);
      cs = 1'b0;
      wait_clk(2 * HALF);
   endtask

   task automatic send_frame(input logic [15:0] f);
      send_bits(f, 16);
      pulse_cs();
   endtask

   task automatic read_reg(input logic [6:0] a, output logic [8:0] v);
      rd_addr = a;
      wait_clk(2);
      v = rd_data;
   endtask

   task automatic test_reset;
      wait_clk(3);
      checks++; if (rd_data !== 9'h000) begin errors++; $display("FAIL reset_rd_data got %h want 000", rd_data); end
      checks++; if (wr_valid !== 1'b0 || frame_err !== 1'b0 || addr_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b%b want 000", wr_valid, frame_err, addr_err); end
      checks++; if (wr_addr !== 7'h00 || wr_data !== 9'h000) begin errors++; $display("FAIL reset_wr got %h/%h want 00/000", wr_addr, wr_data); end
      checks++; if ({active, master, iwl, format, sr, outpd} !== {1'b0, 1'b0, 2'd2, 2'd2, 4'd0, 1'b1}) begin
         errors++; $display("FAIL reset_decoded got act=%b mst=%b iwl=%0d fmt=%0d sr=%0d outpd=%b want 0 0 2 2 0 1",
                            active, master, iwl, format, sr, outpd);
      end
      resetn = 1'b1;
      wait_clk(5);
   endtask

   task automatic test_write_r7;
      int w0, a0;
      logic [8:0] v;
      w0 = wr_cnt; a0 = aerr_cnt;
      send_frame(16'h0E5B);
      checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL r7_wr_valid_cycles got %0d want 1", wr_cnt - w0); end
      checks++; if (aerr_cnt - a0 !== 0) begin errors++; $display("FAIL r7_addr_err got %0d want 0", aerr_cnt - a0); end
      checks++; if (wr_addr !== 7'h07 || wr_data !== 9'h05B) begin errors++; $display("FAIL r7_wr got %h/%h want 07/05b", wr_addr, wr_data); end
      checks++; if ({master, iwl, format} !== {1'b1, 2'd2, 2'd3}) begin
         errors++; $display("FAIL r7_decoded got mst=%b iwl=%0d fmt=%0d want 1 2 3", master, iwl, format);
      end
      read_reg(7'h07, v);
      checks++; if (v !== 9'h05B) begin errors++; $display("FAIL r7_read got %h want 05b", v); end
   endtask

   task automatic test_sr;
      send_frame(16'h1024);
      checks++; if (sr !== 4'd9) begin errors++; $display("FAIL sr_decoded got %0d want 9", sr); end
   endtask

   task automatic test_active_and_soft_reset;
      int w0, a0;
      logic [8:0] v;
      send_frame(16'h1201);
      checks++; if (active !== 1'b1) begin errors++; $display("FAIL active_set got %b want 1", active); end
      w0 = wr_cnt; a0 = aerr_cnt;
      send_frame(16'h1E00);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL active_clear got %b want 0", active); end
      checks++; if (wr_cnt - w0 !== 1 || aerr_cnt - a0 !== 0) begin
         errors++; $display("FAIL softreset_pulses got wr=%0d aerr=%0d want 1 0", wr_cnt - w0, aerr_cnt - a0);
      end
      checks++; if (wr_addr !== 7'h0F) begin errors++; $display("FAIL softreset_wr_addr got %h want 0f", wr_addr); end
      read_reg(7'h07, v);
      checks++; if (v !== 9'h00A) begin errors++; $display("FAIL softreset_r7 got %h want 00a", v); end
      read_reg(7'h08, v);
      checks++; if (v !== 9'h000) begin errors++; $display("FAIL softreset_r8 got %h want 000", v); end
   endtask

   task automatic test_lrboth;
      logic [8:0] v;
      logic [8:0] exp_r1;
`ifdef CODEC_LRBOTH_EN
      exp_r1 = 9'h11F;
`else
      exp_r1 = 9'h097;
`endif
      send_frame(16'h011F);
      read_reg(7'h00, v);
      checks++; if (v !== 9'h11F) begin errors++; $display("FAIL lrboth_r0 got %h want 11f", v); end
      read_reg(7'h01, v);
      checks++; if (v !== exp_r1) begin errors++; $display("FAIL lrboth_r1 got %h want %h", v, exp_r1); end
   endtask

   task automatic test_frame_err;
      int w0, f0;
      logic [8:0] v;
      w0 = wr_cnt; f0 = ferr_cnt;
      send_bits(16'h1201, 15);
      pulse_cs();
      checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL short_frame_err got %0d want 1", ferr_cnt - f0); end
      checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL short_wr_valid got %0d want 0", wr_cnt - w0); end
      read_reg(7'h09, v);
      checks++; if (v !== 9'h000 || active !== 1'b0) begin errors++; $display("FAIL short_bank got r9=%h act=%b want 000 0", v, active); end
      // CS rise with no bits at all
      f0 = ferr_cnt;
      pulse_cs();
      checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL idle_cs_frame_err got %0d want 1", ferr_cnt - f0); end
      // next correct frame is accepted
      w0 = wr_cnt; f0 = ferr_cnt;
      send_frame(16'h1201);
      checks++; if (wr_cnt - w0 !== 1 || ferr_cnt - f0 !== 0 || active !== 1'b1) begin
         errors++; $display("FAIL after_err_frame got wr=%0d ferr=%0d act=%b want 1 0 1", wr_cnt - w0, ferr_cnt - f0, active);
      end
   endtask

   task automatic test_addr_err;
      int w0, a0;
      logic [8:0] v;
      w0 = wr_cnt; a0 = aerr_cnt;
      send_frame(16'h1400);
      checks++; if (wr_cnt - w0 !== 1 || aerr_cnt - a0 !== 1) begin
         errors++; $display("FAIL unmapped_pulses got wr=%0d aerr=%0d want 1 1", wr_cnt - w0, aerr_cnt - a0);
      end
      checks++; if (wr_addr !== 7'h0A || wr_data !== 9'h000) begin errors++; $display("FAIL unmapped_wr got %h/%h want 0a/000", wr_addr, wr_data); end
      read_reg(7'h0A, v);
      checks++; if (v !== 9'h000) begin errors++; $display("FAIL unmapped_read got %h want 000", v); end
      read_reg(7'h07, v);
      checks++; if (v !== 9'h00A || active !== 1'b1) begin errors++; $display("FAIL unmapped_bank got r7=%h act=%b want 00a 1", v, active); end
   endtask

   task automatic test_reset_midframe;
      int w0, f0;
      logic [8:0] v;
      send_bits(16'h0E5B, 8);
      resetn = 1'b0;
      wait_clk(4);
      resetn = 1'b1;
      wait_clk(4);
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL midreset_active got %b want 0", active); end
      w0 = wr_cnt; f0 = ferr_cnt;
      send_frame(16'h0C1C);
      checks++; if (wr_cnt - w0 !== 1 || ferr_cnt - f0 !== 0) begin
         errors++; $display("FAIL midreset_pulses got wr=%0d ferr=%0d want 1 0", wr_cnt - w0, ferr_cnt - f0);
      end
      read_reg(7'h06, v);
      checks++; if (v !== 9'h01C || outpd !== 1'b1) begin errors++; $display("FAIL midreset_r6 got %h outpd=%b want 01c 1", v, outpd); end
      read_reg(7'h07, v);
      checks++; if (v !== 9'h00A) begin errors++; $display("FAIL midreset_r7 got %h want 00a", v); end
   endtask

   initial begin
      test_reset();
      test_write_r7();
      test_sr();
      test_active_and_soft_reset();
      test_lrboth();
      test_frame_err();
      test_addr_err();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
